add_sub_alu_unit: RTL and testbench

- Registered responder wrapped around the existing combinational add_sub_logic datapath.
- Accepts operation requests on a valid/ready channel, computes the 16-bit result, and returns it with a tag on a valid/ready response channel.
- Buffers results in a small output FIFO so that back-pressure does not lose results.
- Sits between any requester (sequencer, bus adapter) and the ALU.

---
 rtl/add_sub_alu_unit_pkg.sv | 25 ++
 rtl/add_sub_alu_unit_if.sv | 35 +++
 rtl/add_sub_alu_unit_logic.sv | 27 ++
 rtl/add_sub_alu_unit.sv | 119 +++++++++++
 tb/tb_add_sub_alu_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/add_sub_alu_unit_pkg.sv
// Shared types and constants for the add/sub ALU responder and its requesters.
// No logic; types only.
// No handshakes; types only.
package alu_pkg;

  // Default operand/result width and tag width of the responder.
  localparam int ALU_WIDTH = 16;
  localparam int ALU_TAG_W = 4;

  // Operation codes carried on req_op.
  typedef enum logic [1:0] {
    OP_ADD      = 2'd0,
    OP_SUB      = 2'd1,
    OP_NXOR_NEG = 2'd2,
    OP_GE       = 2'd3
  } op_e;

  // One response FIFO entry: result, carry/borrow flag, returned tag.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] r;
    logic                 carry;
    logic [ALU_TAG_W-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/add_sub_alu_unit_if.sv
// Request/response valid-ready channel pair between a requester and the ALU.
// No logic; wiring only.
// Standard valid/ready on both channels.
interface add_sub_alu_unit_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;

  // Requester side: issues requests, consumes responses.
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_carry, rsp_tag
  );

  // ALU side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_carry, rsp_tag
  );

endinterface

// File: rtl/add_sub_alu_unit_logic.sv
// Combinational add/sub/neg-xor/compare datapath producing the result word.
// Latency: zero cycles (pure combinational).
// No handshakes; caller decides when the result is captured.
module add_sub_logic
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_r
);

  // Result select; all arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    o_r = '0;
    unique case (i_op)
      OP_ADD:      o_r = i_a + i_b;
      OP_SUB:      o_r = i_a - i_b;
      OP_NXOR_NEG: o_r = -(i_a ^ i_b);
      OP_GE:       o_r = {{(WIDTH-1){1'b0}}, (i_a >= i_b)};
      default:     o_r = '0;
    endcase
  end

endmodule

// File: rtl/add_sub_alu_unit.sv
// Registered ALU responder: computes on request accept, queues {r, carry, tag}.
// Latency: one cycle from accept to rsp_valid when the queue is empty.
// Back-pressure: req_ready drops only when the FIFO is full (from count alone).
module add_sub_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  add_sub_alu_unit_if.slave   bus,
  output logic [15:0]         op_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  // The entry struct lives in the package with fixed widths; refuse to
  // elaborate with a mismatching configuration rather than silently truncate.
  if (WIDTH != ALU_WIDTH || TAG_W != ALU_TAG_W) begin : g_bad_width
    $error("add_sub_alu_unit: WIDTH/TAG_W must match alu_pkg constants");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("add_sub_alu_unit: DEPTH must be >= 2");
  end

  // Datapath
  logic [WIDTH-1:0] w_r;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_carry;
  logic             w_unused_low;

  add_sub_logic #(.WIDTH(WIDTH)) u_logic (
    .i_op (bus.req_op),
    .i_a  (bus.req_a),
    .i_b  (bus.req_b),
    .o_r  (w_r)
  );

  // Carry/borrow comes from a one-bit-wider add/sub kept local to this unit.
  assign w_add = {1'b0, bus.req_a} + {1'b0, bus.req_b};
  assign w_sub = {1'b0, bus.req_a} - {1'b0, bus.req_b};
  // Low bits duplicate add_sub_logic's result and are intentionally dropped.
  assign w_unused_low = ^{w_add[WIDTH-1:0], w_sub[WIDTH-1:0]};

  // Carry only meaningful for add and subtract.
  always_comb begin
    w_carry = 1'b0;
    unique case (bus.req_op)
      OP_ADD:  w_carry = w_add[WIDTH];
      OP_SUB:  w_carry = w_sub[WIDTH];
      default: w_carry = 1'b0;
    endcase
  end

  // FIFO state
  rsp_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_op_count;

  logic       w_accept;
  logic       w_handoff;
  rsp_entry_t w_wr_entry;
  rsp_entry_t w_head;

  assign bus.req_ready = (r_count < DEPTH_C);
  assign bus.rsp_valid = (r_count != '0);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_handoff     = bus.rsp_valid && bus.rsp_ready;

  assign w_wr_entry.r     = w_r;
  assign w_wr_entry.carry = w_carry;
  assign w_wr_entry.tag   = bus.req_tag;

  // Empty queue presents all-zero fields so stale storage never leaks out.
  assign w_head        = bus.rsp_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.rsp_r     = w_head.r;
  assign bus.rsp_carry = w_head.carry;
  assign bus.rsp_tag   = w_head.tag;
  assign op_count      = r_op_count;

  // Storage write on accept; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointers, occupancy and handoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_handoff) begin
        r_rd_ptr   <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        r_op_count <= r_op_count + 16'd1;
      end
      unique case ({w_accept, w_handoff})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_alu_unit.sv
// Scoreboard bench for add_sub_alu_unit: directed vectors, queued expectations.
// Responses are checked by an independent monitor every cycle rsp_valid is high.
// Exercises stall, full, reset-while-busy and op_count wrap.
module tb_add_sub_alu_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  add_sub_alu_unit_if #(.WIDTH(16), .TAG_W(4)) bus ();

  add_sub_alu_unit #(.WIDTH(16), .DEPTH(2), .TAG_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 2ns after the falling edge, after the driver has settled.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && bus.rsp_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got r=0x%0h tag=%0d, expected no response (t=%0t)",
                 bus.rsp_r, bus.rsp_tag, $time);
      end else begin
        chk("rsp_r", {16'h0, bus.rsp_r}, {16'h0, q[0].r});
        chk("rsp_carry", {31'h0, bus.rsp_carry}, {31'h0, q[0].c});
        chk("rsp_tag", {28'h0, bus.rsp_tag}, {28'h0, q[0].tag});
        if (bus.rsp_ready) void'(q.pop_front());
      end
    end
  end

  // Issue one request; called at a falling edge, returns at the falling edge
  // after the accepting rising edge with req_valid dropped.
  task automatic send(input op_e op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input logic [15:0] er, input logic ec,
                      output int waits);
    exp_t e;
    waits = 0;
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      e.r = er; e.c = ec; e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  int w;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_ADD;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h5678;
    bus.req_tag   = 4'hA;
    bus.rsp_ready = 1'b1;

    // Reset state (req_valid low with junk payload must not matter)
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_op_count", {16'h0, op_count}, 32'd0);
    chk("rst_rsp_r", {16'h0, bus.rsp_r}, 32'd0);
    chk("rst_rsp_tag", {28'h0, bus.rsp_tag}, 32'd0);
    @(negedge clk);
    chk("idle_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);

    // First transaction: 2 + 3, one-cycle latency
    send(OP_ADD, 16'd2, 16'd3, 4'd1, 16'd5, 1'b0, w);
    chk("lat1_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    chk("op_count_1", {16'h0, op_count}, 32'd1);

    // Back-to-back with rsp_ready high
    send(OP_SUB, 16'd10, 16'd5, 4'd2, 16'h0005, 1'b0, w);        chk("b2b_ready0", w, 0);
    send(OP_SUB, 16'd100, 16'd200, 4'd3, 16'hFF9C, 1'b1, w);     chk("b2b_ready1", w, 0);
    send(OP_NXOR_NEG, 16'd7, 16'd11, 4'd4, 16'hFFF4, 1'b0, w);   chk("b2b_ready2", w, 0);
    send(OP_GE, 16'd3, 16'd10, 4'd5, 16'h0000, 1'b0, w);         chk("b2b_ready3", w, 0);
    send(OP_GE, 16'd10, 16'd3, 4'd6, 16'h0001, 1'b0, w);         chk("b2b_ready4", w, 0);
    drain();
    chk("op_count_6", {16'h0, op_count}, 32'd6);

    // Stall: two accepted, third held until one handoff
    bus.rsp_ready = 1'b0;
    send(OP_ADD, 16'd1, 16'd1, 4'd7, 16'd2, 1'b0, w);            chk("stall_acc0", w, 0);
    send(OP_ADD, 16'd2, 16'd2, 4'd8, 16'd4, 1'b0, w);            chk("stall_acc1", w, 0);
    bus.req_op = OP_ADD; bus.req_a = 16'd3; bus.req_b = 16'd3; bus.req_tag = 4'd9;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_req_ready", {31'h0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("full_op_count", {16'h0, op_count}, 32'd6);
    bus.rsp_ready = 1'b1;
    send(OP_ADD, 16'd3, 16'd3, 4'd9, 16'd6, 1'b0, w);
    chk("full_waited", w, 1);
    drain();
    chk("op_count_9", {16'h0, op_count}, 32'd9);

    // Boundaries
    send(OP_ADD, 16'hFFFF, 16'h0001, 4'd10, 16'h0000, 1'b1, w);
    send(OP_GE, 16'd64, 16'd65, 4'd11, 16'h0000, 1'b0, w);
    send(OP_GE, 16'd12, 16'd7, 4'd12, 16'h0001, 1'b0, w);
    drain();

    // Reset while the queue is full
    bus.rsp_ready = 1'b0;
    send(OP_SUB, 16'd9, 16'd1, 4'd13, 16'd8, 1'b0, w);
    send(OP_SUB, 16'd9, 16'd2, 4'd14, 16'd7, 1'b0, w);
    chk("prerst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
    chk("prerst_req_ready", {31'h0, bus.req_ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("arst_op_count", {16'h0, op_count}, 32'd0);
    chk("arst_rsp_r", {16'h0, bus.rsp_r}, 32'd0);
    chk("arst_rsp_carry", {31'h0, bus.rsp_carry}, 32'd0);
    chk("arst_rsp_tag", {28'h0, bus.rsp_tag}, 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", {31'h0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("postrst_no_stale", {31'h0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
    end

    // op_count wrap: 65535 handoffs reach 0xFFFF, one more wraps to 0
    for (int i = 0; i < 65535; i++) begin
      send(OP_ADD, 16'(i), 16'h0000, 4'(i), 16'(i), 1'b0, w);
    end
    drain();
    chk("op_count_ffff", {16'h0, op_count}, 32'h0000FFFF);
    send(OP_SUB, 16'd5, 16'd5, 4'd15, 16'd0, 1'b0, w);
    drain();
    chk("op_count_wrap", {16'h0, op_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
